// File: rtl/mem_block_copy.sv
// Memory-to-memory block copier: one READ/WRITE pair per element, ascending order.
// Optional running checksum of copied data is built only with COPY_CHECKSUM_EN defined.
`timescale 1ns/1ps
module mem_block_copy #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [ADDR_W-1:0] SrcAddr,
   input  logic [ADDR_W-1:0] DstAddr,
   input  logic [ADDR_W-1:0] Length,
   output logic              Busy,
   output logic              Done,
   output logic [ADDR_W-1:0] MemAddress,
   output logic [DATA_W-1:0] MemWriteData,
   output logic              MemWrite,
   output logic              MemRead,
   input  logic [DATA_W-1:0] MemReadData,
   output logic [DATA_W-1:0] Checksum
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_t            state_q;
   logic [ADDR_W-1:0] src_q, dst_q, len_q, idx_q, idx_d, addr_q;
   logic [DATA_W-1:0] hold_q;
   logic              rd_q, wr_q, busy_q, done_q;
`ifdef COPY_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q;
`endif

   // Address arithmetic keeps ADDR_W bits, so the carry out is dropped.
   assign idx_d = idx_q + ONE;

   // NOTE: all state below uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create ordering-dependent races.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         hold_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef COPY_CHECKSUM_EN
         checksum_q <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (Start) begin
                  src_q  <= SrcAddr;
                  dst_q  <= DstAddr;
                  len_q  <= Length;
                  idx_q  <= '0;
                  busy_q <= 1'b1;
`ifdef COPY_CHECKSUM_EN
                  checksum_q <= '0;
`endif
                  if (Length != '0) begin
                     state_q <= S_READ;
                     addr_q  <= SrcAddr;
                     rd_q    <= 1'b1;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               hold_q  <= MemReadData;
               state_q <= S_WRITE;
               rd_q    <= 1'b0;
               wr_q    <= 1'b1;
               addr_q  <= dst_q + idx_q;
            end
            S_WRITE: begin
               idx_q <= idx_d;
               wr_q  <= 1'b0;
`ifdef COPY_CHECKSUM_EN
               checksum_q <= checksum_q + hold_q;
`endif
               if (idx_d == len_q) begin
                  state_q <= S_DONE;
                  addr_q  <= '0;
                  done_q  <= 1'b1;
               end else begin
                  // Next read is issued only after this write commits, so overlapping
                  // ranges see already-copied data.
                  state_q <= S_READ;
                  rd_q    <= 1'b1;
                  addr_q  <= src_q + idx_d;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // NOTE: outputs are masked by Reset combinationally so a reset raised during a
   // WRITE cycle suppresses that cycle's memory commit, not just later ones.
   assign Busy         = busy_q & ~Reset;
   assign Done         = done_q & ~Reset;
   assign MemRead      = rd_q & ~Reset;
   assign MemWrite     = wr_q & ~Reset;
   assign MemAddress   = Reset ? '0 : addr_q;
   assign MemWriteData = (wr_q && !Reset) ? hold_q : '0;

`ifdef COPY_CHECKSUM_EN
   assign Checksum = Reset ? '0 : checksum_q;
`else
   assign Checksum = '0;
`endif

endmodule
